// File: rtl/custom_clk.sv
// Programmable rate divider: emits a single-cycle enable strobe every `period` clk cycles.
// The strobe is a clock enable for logic in the clk domain, not a derived clock.
module custom_clk (
    input  logic        resetn,
    input  logic        clk,
    input  logic [25:0] period,
    output logic        pulse
);

    logic [25:0] r_cnt;
    logic        r_pulse;
    logic [25:0] w_term;
    logic        w_fire;

    // Zero is treated as one, so the terminal value never underflows to all-ones.
    assign w_term = (period == 26'd0) ? 26'd0 : (period - 26'd1);

    // >= rather than == so that lowering the period below the running count fires at once
    // instead of letting the counter run up to 2^26 and wrap.
    assign w_fire = (r_cnt >= w_term);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= 26'd0;
            r_pulse <= 1'b0;
        end else if (w_fire) begin
            r_cnt   <= 26'd0;
            r_pulse <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + 26'd1;
            r_pulse <= 1'b0;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: tb/tb_custom_clk.sv
// Bench for custom_clk: per-edge scoreboard against an interval-length model, plus
// directed checks of absolute pulse times after reset release.
module tb_custom_clk;

    logic        resetn;
    logic        clk;
    logic [25:0] period;
    logic        pulse;

    int total = 0;
    int bad   = 0;

    int cyc  = 0;
    int base = 0;
    int k    = 0;
    logic exp_q[$];
    int   pulse_times[$];
    int   exp_t[$];

    custom_clk dut (
        .resetn (resetn),
        .clk    (clk),
        .period (period),
        .pulse  (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count edges since the interval began; fire once that count reaches
    // the effective period currently on the input.
    always @(posedge clk) begin
        int p;
        cyc = cyc + 1;
        if (!resetn) begin
            k = 0;
            exp_q.push_back(1'b0);
        end else begin
            p = (period == 26'd0) ? 1 : int'(period);
            k = k + 1;
            if (k >= p) begin
                k = 0;
                exp_q.push_back(1'b1);
            end else begin
                exp_q.push_back(1'b0);
            end
        end
    end

    always @(posedge clk) begin
        logic e;
        #1;
        total = total + 1;
        if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_empty cycle=%0d got=%0b want=an expected entry", cyc, pulse);
        end else begin
            e = exp_q.pop_front();
            if (pulse !== e) begin
                bad = bad + 1;
                $display("FAIL pulse_cycle cycle=%0d got=%0b want=%0b", cyc, pulse, e);
            end
        end
        if (pulse === 1'b1) pulse_times.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_async_low(input string name);
        #1;
        total = total + 1;
        if (pulse !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL %s got=%0b want=0", name, pulse);
        end
    endtask

    // Called at a negedge: hold reset across two edges, then release.
    task automatic reset_release(input logic [25:0] p);
        period = p;
        resetn = 1'b0;
        check_async_low("async_reset");
        tick(2);
        resetn = 1'b1;
        base = cyc;
        pulse_times.delete();
    endtask

    task automatic check_times(input string name);
        total = total + 1;
        if (pulse_times.size() != exp_t.size()) begin
            bad = bad + 1;
            $display("FAIL %s_count got=%0d want=%0d", name, pulse_times.size(), exp_t.size());
        end else begin
            foreach (exp_t[i]) begin
                total = total + 1;
                if (pulse_times[i] - base != exp_t[i]) begin
                    bad = bad + 1;
                    $display("FAIL %s_edge[%0d] got=%0d want=%0d", name, i,
                             pulse_times[i] - base, exp_t[i]);
                end
            end
        end
        exp_t.delete();
    endtask

    initial begin
        resetn = 1'b0;
        period = 26'd3;
        tick(3);
        total = total + 1;
        if (pulse !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_state got=%0b want=0", pulse);
        end

        // Reset behaviour, including async assertion mid-count.
        resetn = 1'b1;
        tick(4);
        reset_release(26'd3);
        tick(10);
        exp_t = '{3, 6, 9};
        check_times("period3");

        // Long period, three intervals.
        reset_release(26'd4999);
        tick(3 * 4999 + 5);
        exp_t = '{4999, 9998, 14997};
        check_times("large");

        // Degenerate periods.
        reset_release(26'd1);
        tick(5);
        exp_t = '{1, 2, 3, 4, 5};
        check_times("period1");
        reset_release(26'd0);
        tick(5);
        exp_t = '{1, 2, 3, 4, 5};
        check_times("period0");

        // Lowered mid-count at cnt = 50.
        reset_release(26'd100);
        tick(50);
        period = 26'd10;
        tick(25);
        exp_t = '{51, 61, 71};
        check_times("lowered");

        // Raised mid-count at cnt = 5.
        reset_release(26'd10);
        tick(5);
        period = 26'd20;
        tick(40);
        exp_t = '{20, 40};
        check_times("raised");

        // Reset two cycles before terminal count.
        reset_release(26'd8);
        tick(6);
        resetn = 1'b0;
        check_async_low("midcount_reset");
        tick(3);
        total = total + 1;
        if (pulse_times.size() != 0) begin
            bad = bad + 1;
            $display("FAIL midcount_no_pulse got=%0d want=0", pulse_times.size());
        end
        resetn = 1'b1;
        base = cyc;
        tick(17);
        exp_t = '{8, 16};
        check_times("midcount_resume");

        // Randomized period changes and resets, checked by the scoreboard.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 19) == 0)
                period = 26'h3FF_FFFF;
            else
                period = 26'($urandom_range(0, 30));
            if ($urandom_range(0, 9) == 0) begin
                resetn = 1'b0;
                check_async_low("rand_reset");
                tick($urandom_range(1, 3));
                resetn = 1'b1;
            end
            tick($urandom_range(1, 40));
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
